// File: rtl/board_input_conditioner_if.sv
// Board-side pin bundle for the input conditioner: raw KEY/SW pins in,
// debounced levels and per-bit edge pulses out.
interface board_input_conditioner_if #(
    parameter int KEY_W = 2,
    parameter int SW_W  = 10
);
    logic [KEY_W-1:0] key_n_in;
    logic [SW_W-1:0]  sw_in;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic [SW_W-1:0]  sw_out;
    logic [SW_W-1:0]  sw_change;

    modport master (
        output key_n_in, sw_in,
        input  key_out, key_press, key_release, sw_out, sw_change
    );

    modport slave (
        input  key_n_in, sw_in,
        output key_out, key_press, key_release, sw_out, sw_change
    );
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronises, debounces and edge-detects DE10-Lite pushbuttons and switches.
// Every bit is an independent channel: 2-flop sync, stable-count debounce, edge pulses.
module board_input_conditioner #(
    parameter int KEY_W           = 2,
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic clk,
    input logic reset_n,
    board_input_conditioner_if.slave bus
);
    localparam int N = KEY_W + SW_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] raw;
    logic [N-1:0] s1_p0;
    logic [N-1:0] s2_p1;
    logic [N-1:0] state;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] chg;

    // Keys are active-low on the board; invert so every channel is active-high.
    assign raw = {bus.sw_in, ~bus.key_n_in};

    // Stage p0/p1: two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_p0 <= '0;
            s2_p1 <= '0;
        end else begin
            s1_p0 <= raw;
            s2_p1 <= s1_p0;
        end
    end

    // Stage p2: per-channel debounce counter, accepted level and edge pulses
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             up;
        logic             down;
        logic             toggle;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt    <= '0;
                level  <= 1'b0;
                up     <= 1'b0;
                down   <= 1'b0;
                toggle <= 1'b0;
            end else begin
                up     <= 1'b0;
                down   <= 1'b0;
                toggle <= 1'b0;
                if (s2_p1[i] == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    level  <= s2_p1[i];
                    cnt    <= '0;
                    up     <= s2_p1[i];
                    down   <= ~s2_p1[i];
                    toggle <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign state[i] = level;
        assign rise[i]  = up;
        assign fall[i]  = down;
        assign chg[i]   = toggle;
    end

    assign bus.key_out     = state[KEY_W-1:0];
    assign bus.key_press   = rise[KEY_W-1:0];
    assign bus.key_release = fall[KEY_W-1:0];
    assign bus.sw_out      = state[N-1:KEY_W];
    assign bus.sw_change   = chg[N-1:KEY_W];
endmodule
